// File: rtl/shift_76_line_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_76_line_buffer_if
// Description : Access bus of the 76 x 32-bit line buffer. It carries the
//               write/read request, the word address and data, and returns
//               the previous word content and the ready flag.
// Ports       : write_en (req), wr_addr[6:0], wr_data[31:0] -> buffer
//               rd_data[31:0], ready                          <- buffer
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_76_line_buffer_if;
  logic        write_en;
  logic [6:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ready;

  // Client side: issues requests, receives previous contents.
  modport master (
    output write_en,
    output wr_addr,
    output wr_data,
    input  rd_data,
    input  ready
  );

  // Buffer side.
  modport slave (
    input  write_en,
    input  wr_addr,
    input  wr_data,
    output rd_data,
    output ready
  );
endinterface
`default_nettype wire

// File: rtl/shift_76_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : shift_76_line_buffer
// Description : Addressed 76-entry x 32-bit line buffer. Each accepted write
//               stores wr_data at wr_addr and returns (one clock later) the
//               word previously held there, so a circular address sweep gives
//               a fixed-length delay line. After reset the storage is cleared
//               one word per cycle, then ready is raised.
// Ports       : clk    - clock, rising edge
//               reset  - asynchronous, active-high reset
//               bus    - slave side of shift_76_line_buffer_if
//                        (write_en, wr_addr, wr_data in; rd_data, ready out)
// Revision    : 1.0 - initial release
// ============================================================================
module shift_76_line_buffer (
  input  wire                          clk,
  input  wire                          reset,
  shift_76_line_buffer_if.slave        bus
);

  localparam int        DEPTH     = 76;
  localparam logic [6:0] LAST_ADDR = 7'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [31:0] rd_data_q;
  logic        clr_en;
  logic        acc_en;
  logic        in_range;

  logic [31:0] memory [0:DEPTH-1];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next state: INIT clears word cnt_q each cycle; the edge that clears the
  // last word also moves to RUN, so ready is seen the cycle after edge 76.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    case (state_q)
      S_INIT: begin
        clr_en = 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = 7'd0;
      end
    endcase
  end

  assign in_range = (bus.wr_addr <= LAST_ADDR);
  // Requests are only honoured in RUN; write_en during init is ignored.
  assign acc_en   = bus.write_en && (state_q == S_RUN);

  // --------------------------------------------------------------------------
  // Storage. Not reset; it is scrubbed by the init sweep instead. Holding
  // reset high blocks writes so an edge coinciding with reset is discarded.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clr_en) begin
        memory[cnt_q] <= 32'd0;
      end else if (acc_en && in_range) begin
        memory[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read-before-write: the nonblocking write above means this samples the
  // old contents on the same edge. Out-of-range accesses return zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_q <= 32'd0;
    end else if (acc_en) begin
      rd_data_q <= in_range ? memory[bus.wr_addr] : 32'd0;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.ready   = (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_shift_76_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_76_line_buffer
// Description : Directed self-checking bench for shift_76_line_buffer with a
//               reference memory and an expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_76_line_buffer;

  logic clk;
  logic reset;

  shift_76_line_buffer_if bus_if ();

  shift_76_line_buffer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_err;
  logic [31:0] model [0:75];
  logic [31:0] last_exp;
  logic [31:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, compare just after the rising edge.
  task automatic access(input logic en, input logic [6:0] addr, input logic [31:0] data,
                        input string tag);
    logic [31:0] exp;
    @(negedge clk);
    bus_if.write_en = en;
    bus_if.wr_addr  = addr;
    bus_if.wr_data  = data;
    if (en && addr <= 7'd75) begin
      exp         = model[addr];
      model[addr] = data;
    end else if (en) begin
      exp = 32'd0;
    end else begin
      exp = last_exp;
    end
    last_exp = exp;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    check(tag, bus_if.rd_data, sb.pop_front());
  endtask

  // Counts edges after release: ready must be low through edge 75, high at 76.
  task automatic init_sweep(input string tag);
    for (int e = 1; e <= 76; e++) begin
      @(posedge clk);
      #1;
      check(tag, {31'd0, bus_if.ready}, {31'd0, (e == 76)});
    end
    @(negedge clk);
    bus_if.write_en = 1'b0;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    last_exp = 32'd0;
    for (int i = 0; i < 76; i++) model[i] = 32'd0;
    reset           = 1'b1;
    bus_if.write_en = 1'b0;
    bus_if.wr_addr  = 7'd0;
    bus_if.wr_data  = 32'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, bus_if.ready}, 32'd0);
    check("rst_rd_data", bus_if.rd_data, 32'd0);

    // Release with a request pending: it must be ignored during the clear.
    reset           = 1'b0;
    bus_if.write_en = 1'b1;
    bus_if.wr_addr  = 7'd3;
    bus_if.wr_data  = 32'h5555_5555;
    init_sweep("init_ready");
    check("init_rd_data", bus_if.rd_data, 32'd0);

    // First pass: addresses 0..72, data 1..73, all reads return zero.
    for (int a = 0; a <= 72; a++) access(1'b1, 7'(a), 32'(a + 1), "first_pass");

    // Wrap pass, first part.
    for (int a = 0; a <= 36; a++) access(1'b1, 7'(a), 32'(74 + a), "wrap_pass");

    // Stall: rd_data must hold.
    for (int s = 0; s < 10; s++) access(1'b0, 7'(s), 32'hFFFF_FFFF, "stall_hold");

    // Resume: remaining addresses must return the word written 73 writes ago.
    for (int a = 37; a <= 72; a++) access(1'b1, 7'(a), 32'(74 + a), "resume");

    // Boundary addresses.
    access(1'b1, 7'd75, 32'hDEAD_BEEF, "addr75_first");
    access(1'b1, 7'd75, 32'h1234_5678, "addr75_readback");
    access(1'b1, 7'd76, 32'hAAAA_0001, "addr76_zero");
    access(1'b1, 7'd127, 32'hAAAA_0002, "addr127_zero");
    access(1'b1, 7'd75, 32'h0BAD_0075, "addr75_untouched");
    access(1'b1, 7'd0, 32'h0000_C000, "addr0_untouched");
    access(1'b1, 7'd63, 32'h0000_C063, "addr63_untouched");
    access(1'b1, 7'd12, 32'h0000_C012, "addr12_untouched");

    // Same address on consecutive cycles.
    access(1'b1, 7'd10, 32'hCAFE_0010, "same_addr_a");
    access(1'b1, 7'd10, 32'hCAFE_0011, "same_addr_b");
    access(1'b1, 7'd10, 32'hCAFE_0012, "same_addr_c");

    // Part of another wrap pass, then asynchronous reset between edges.
    for (int a = 20; a <= 30; a++) access(1'b1, 7'(a), 32'(500 + a), "pre_reset");
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_ready", {31'd0, bus_if.ready}, 32'd0);
    check("async_rst_rd_data", bus_if.rd_data, 32'd0);
    // A request held through an edge under reset must be discarded.
    bus_if.write_en = 1'b1;
    bus_if.wr_addr  = 7'd5;
    bus_if.wr_data  = 32'h0BAD_BAD5;
    @(posedge clk);
    #1;
    check("rst_hold_ready", {31'd0, bus_if.ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < 76; i++) model[i] = 32'd0;
    last_exp = 32'd0;
    init_sweep("reinit_ready");

    // After the second clear every word reads back as zero.
    for (int a = 0; a <= 75; a++) access(1'b1, 7'(a), 32'(1000 + a), "post_reset_pass");
    // And the pass just written reads back.
    for (int a = 0; a <= 75; a++) access(1'b1, 7'(a), 32'(2000 + a), "post_reset_readback");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
